// File: rtl/im_port_arbiter_pkg.sv
// Shared constants and owner encoding for the instruction-memory port arbiter.
// The IM window starts at IM_BASE and spans 4*2^IM_ADDR_W bytes.
package im_port_arbiter_pkg;
   localparam logic [31:0] IM_BASE       = 32'h0000_3000;
   localparam int          IM_ADDR_W     = 12;
   localparam int          IM_STARVE_MAX = 4;

   typedef enum logic [1:0] {
      IM_OWN_NONE = 2'd0,
      IM_OWN_IF   = 2'd1,
      IM_OWN_LD   = 2'd2
   } im_owner_e;
endpackage

// File: rtl/im_port_arbiter_addr_check.sv
// Byte address -> IM word index, with alignment and window range check (combinational).
module im_addr_check
   import im_port_arbiter_pkg::*;
#(
   parameter logic [31:0] BASE = IM_BASE,
   parameter int          AW   = IM_ADDR_W
) (
   input  logic [31:0]   addr_i,
   output logic [AW-1:0] idx_o,
   output logic          err_o
);
   logic [31:0] diff;

   assign diff  = addr_i - BASE;
   assign idx_o = diff[AW+1:2];
   // BASE is word aligned, so diff[1:0] mirrors addr_i[1:0]; any bit above the
   // window size means the address lies past the top of IM.
   assign err_o = (diff[1:0] != 2'b00) || (addr_i < BASE) || ((diff >> (AW + 2)) != 32'd0);
endmodule

// File: rtl/im_port_arbiter.sv
// Two-port arbiter for the single-bank IM: fetch has priority, the loader gets a forced
// grant after STARVE_MAX consecutive denials; 1-cycle read data is routed to the owner.
module im_port_arbiter
   import im_port_arbiter_pkg::*;
#(
   parameter logic [31:0] IM_BASE    = im_port_arbiter_pkg::IM_BASE,
   parameter int          ADDR_W     = IM_ADDR_W,
   parameter int          STARVE_MAX = IM_STARVE_MAX
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   output logic              if_adel,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [31:0]       ld_addr,
   input  logic [31:0]       ld_wdata,
   output logic              ld_gnt,
   output logic              ld_rvalid,
   output logic [31:0]       ld_rdata,
   output logic              ld_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);
   localparam int             SW   = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0]  SMAX = SW'(STARVE_MAX);

   logic [ADDR_W-1:0] if_idx, ld_idx;
   logic              if_bad, ld_bad;
   logic              ld_win;
   logic [SW-1:0]     starve_q, starve_d;
   im_owner_e         owner_q, owner_d;
   logic              err_q, err_d;
   logic              wr_q, wr_d;

   im_addr_check #(.BASE(IM_BASE), .AW(ADDR_W)) u_if_chk (
      .addr_i (if_addr),
      .idx_o  (if_idx),
      .err_o  (if_bad)
   );

   im_addr_check #(.BASE(IM_BASE), .AW(ADDR_W)) u_ld_chk (
      .addr_i (ld_addr),
      .idx_o  (ld_idx),
      .err_o  (ld_bad)
   );

   always_comb begin
      ld_win    = 1'b0;
      if_gnt    = 1'b0;
      ld_gnt    = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      owner_d   = IM_OWN_NONE;
      err_d     = 1'b0;
      wr_d      = 1'b0;
      starve_d  = starve_q;

      // Nothing is granted while reset is held, so no access can start mid-reset.
      if (reset) begin
         ld_win = ld_req && (!if_req || (starve_q == SMAX));
         ld_gnt = ld_win;
         if_gnt = if_req && !ld_win;
      end

      if (if_gnt) begin
         mem_en   = !if_bad;
         mem_addr = if_idx;
         owner_d  = IM_OWN_IF;
         err_d    = if_bad;
      end else if (ld_gnt) begin
         mem_en    = !ld_bad;
         mem_we    = ld_we && !ld_bad;
         mem_addr  = ld_idx;
         mem_wdata = ld_wdata;
         owner_d   = IM_OWN_LD;
         err_d     = ld_bad;
         wr_d      = ld_we;
      end

      if (!ld_req || ld_gnt)    starve_d = '0;
      else if (starve_q != SMAX) starve_d = starve_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_q <= '0;
         owner_q  <= IM_OWN_NONE;
         err_q    <= 1'b0;
         wr_q     <= 1'b0;
      end else begin
         starve_q <= starve_d;
         owner_q  <= owner_d;
         err_q    <= err_d;
         wr_q     <= wr_d;
      end
   end

   // Responses are decoded from the owner register; bank data is passed only for legal reads.
   always_comb begin
      if_rvalid = (owner_q == IM_OWN_IF);
      ld_rvalid = (owner_q == IM_OWN_LD);
      if_adel   = if_rvalid && err_q;
      ld_err    = ld_rvalid && err_q;
      if_rdata  = (if_rvalid && !err_q) ? mem_rdata : 32'd0;
      ld_rdata  = (ld_rvalid && !err_q && !wr_q) ? mem_rdata : 32'd0;
   end
endmodule

// File: tb/tb_im_port_arbiter.sv
// Directed and randomized check of im_port_arbiter against a grant/memory reference model.
module tb_im_port_arbiter;
   localparam logic [31:0] BASE = 32'h0000_3000;
   localparam longint      WIN  = 16384;
   localparam int          SMAX = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, ld_req, ld_we;
   logic [31:0] if_addr, ld_addr, ld_wdata;
   logic        if_gnt, if_rvalid, if_adel, ld_gnt, ld_rvalid, ld_err;
   logic [31:0] if_rdata, ld_rdata;
   logic        mem_en, mem_we;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   logic [31:0] bank [0:4095];
   logic        pl_en;
   logic [11:0] pl_idx;
   logic [31:0] pl_dat;

   logic [31:0] ref_mem [0:4095];
   int          total = 0, bad = 0, denials = 0;
   bit          e_if_v, e_ld_v, e_err;
   logic [31:0] e_dat;
   bit          last_if_gnt, last_ld_gnt, last_mem_en;

   always #5 clk = ~clk;

   im_port_arbiter dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_adel(if_adel),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_err(ld_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Synchronous bank with 1-cycle read latency plus a backdoor preload port.
   always @(posedge clk) begin
      if (pl_en) bank[pl_idx] <= pl_dat;
      else if (mem_en) begin
         if (mem_we) bank[mem_addr] <= mem_wdata;
         mem_rdata <= bank[mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit legal(input logic [31:0] a);
      longint la = longint'(a);
      return (la % 4 == 0) && (la >= longint'(BASE)) && (la < longint'(BASE) + WIN);
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((longint'(a) - longint'(BASE)) / 4);
   endfunction

   // One clock: check last grant's response, check this cycle's grant/bank drive, advance model.
   task automatic cycle();
      bit eif, eld, ok;
      logic [31:0] a;
      int idx;
      @(negedge clk);
      chk("if_rvalid", if_rvalid, e_if_v);
      chk("if_rdata",  if_rdata,  e_if_v ? e_dat : 32'd0);
      chk("if_adel",   if_adel,   e_if_v && e_err);
      chk("ld_rvalid", ld_rvalid, e_ld_v);
      chk("ld_rdata",  ld_rdata,  e_ld_v ? e_dat : 32'd0);
      chk("ld_err",    ld_err,    e_ld_v && e_err);
      eld = ld_req && (!if_req || denials >= SMAX);
      eif = if_req && !eld;
      chk("if_gnt", if_gnt, eif);
      chk("ld_gnt", ld_gnt, eld);
      last_if_gnt = if_gnt; last_ld_gnt = ld_gnt; last_mem_en = mem_en;
      e_if_v = eif; e_ld_v = eld; e_dat = 32'd0; e_err = 1'b0;
      if (eif || eld) begin
         a = eif ? if_addr : ld_addr;
         ok = legal(a);
         e_err = !ok;
         chk("mem_en", mem_en, ok);
         chk("mem_we", mem_we, eld && ld_we && ok);
         if (ok) begin
            idx = widx(a);
            chk("mem_addr", mem_addr, idx);
            if (eld && ld_we) begin
               chk("mem_wdata", mem_wdata, ld_wdata);
               ref_mem[idx] = ld_wdata;
            end else e_dat = ref_mem[idx];
         end
      end else begin
         chk("idle_mem_en", mem_en, 0);
         chk("idle_mem_we", mem_we, 0);
         chk("idle_mem_addr", mem_addr, 0);
         chk("idle_mem_wdata", mem_wdata, 0);
      end
      denials = (ld_req && !eld) ? ((denials < SMAX) ? denials + 1 : denials) : 0;
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] rand_addr();
      int r = $urandom_range(0, 11);
      case (r)
         8:  return 32'h0000_2FFC;
         9:  return 32'h0000_3000 + $urandom_range(1, 3);
         10: return 32'h0000_7000;
         11: return 32'h0000_6FFC;
         default: return BASE + 4 * $urandom_range(0, 15);
      endcase
   endfunction

   initial begin
      reset = 1'b0; if_req = 0; ld_req = 0; ld_we = 0;
      if_addr = 0; ld_addr = 0; ld_wdata = 0;
      pl_en = 1'b1; pl_idx = 0; pl_dat = 0;
      // Backdoor preload of the reachable words while the arbiter is held in reset.
      for (int i = 0; i < 65; i++) begin
         pl_idx = (i == 64) ? 12'hFFF : i[11:0];
         pl_dat = (i == 1) ? 32'h2408_0005 : (i == 0) ? 32'h1111_0000 : $urandom;
         ref_mem[int'(pl_idx)] = pl_dat;
         @(posedge clk); #1;
      end
      pl_en = 1'b0;

      if_req = 1; if_addr = 32'h3004;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_if_rvalid", if_rvalid, 0); chk("rst_ld_rvalid", ld_rvalid, 0);
      chk("rst_if_adel", if_adel, 0);     chk("rst_ld_err", ld_err, 0);
      chk("rst_if_rdata", if_rdata, 0);   chk("rst_ld_rdata", ld_rdata, 0);
      chk("rst_mem_en", mem_en, 0);       chk("rst_if_gnt", if_gnt, 0);
      @(posedge clk); #1 reset = 1'b1;

      cycle();
      if_req = 0;
      chk("fetch_word1_data", if_rdata, 32'h2408_0005);
      chk("fetch_word1_valid", if_rvalid, 1);
      cycle();

      // Fetch hogging the port: the loader must win on the fifth cycle.
      if_req = 1; if_addr = 32'h3004; ld_req = 1; ld_we = 0; ld_addr = 32'h3008;
      for (int k = 0; k < 6; k++) begin
         cycle();
         chk("starve_ld_gnt", last_ld_gnt, k == 4);
         if (k == 4) ld_req = 0;
         if (k == 5) chk("starve_if_resume", last_if_gnt, 1);
      end
      if_req = 0;
      cycle();

      ld_req = 1; ld_we = 1; ld_addr = 32'h3010; ld_wdata = 32'hDEAD_BEEF;
      cycle();
      ld_req = 0; if_req = 1; if_addr = 32'h3010;
      cycle();
      if_req = 0;
      chk("write_then_fetch", if_rdata, 32'hDEAD_BEEF);
      cycle();

      for (int e = 0; e < 3; e++) begin
         if_req = 1;
         if_addr = (e == 0) ? 32'h2FFC : (e == 1) ? 32'h3002 : 32'h7000;
         cycle();
         if_req = 0;
         chk("err_if_gnt", last_if_gnt, 1);
         chk("err_mem_en", last_mem_en, 0);
         chk("err_if_adel", if_adel, 1);
         chk("err_if_rdata", if_rdata, 0);
      end
      ld_req = 1; ld_we = 1; ld_addr = 32'h7000; ld_wdata = 32'h1234_5678;
      cycle();
      ld_req = 0;
      chk("err_ld_err", ld_err, 1);
      cycle();
      chk("err_bank_unchanged", bank[0], 32'h1111_0000);

      // Reset between grant and response: the response must be dropped.
      if_req = 1; if_addr = 32'h3004;
      @(negedge clk);
      chk("midrst_gnt", if_gnt, 1);
      reset = 1'b0; if_req = 0;
      for (int r = 0; r < 2; r++) begin
         @(posedge clk); #1;
         chk("midrst_no_rvalid", if_rvalid, 0);
      end
      reset = 1'b1;
      e_if_v = 0; e_ld_v = 0; denials = 0;
      cycle();

      for (int n = 0; n < 400; n++) begin
         if (!if_req && ($urandom_range(0, 3) != 0)) begin
            if_req = 1; if_addr = rand_addr();
         end
         if (!ld_req && ($urandom_range(0, 2) == 0)) begin
            ld_req = 1; ld_addr = rand_addr(); ld_we = $urandom_range(0, 1); ld_wdata = $urandom;
         end
         cycle();
         if (last_if_gnt) if_req = 0;
         if (last_ld_gnt) ld_req = 0;
      end
      if_req = 0; ld_req = 0;
      cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule
